// File: rtl/mbisr_chain_pkg.sv
// Shared types and default sizes for the MBISR repair-chain sequencer.
package mbisr_chain_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int LEN_W_DEF  = 6;

   typedef enum logic [1:0] {
      OP_NOP           = 2'd0,
      OP_CAPTURE       = 2'd1,
      OP_SHIFT         = 2'd2,
      OP_CAPTURE_SHIFT = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_SHIFT   = 2'd2,
      ST_RESP    = 2'd3
   } state_e;

endpackage

// File: rtl/mbisr_chain_shifter.sv
// Bit counter, serializer for chain SI and deserializer for chain SO.
module mbisr_chain_shifter
   import mbisr_chain_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic              shift_i,
   input  logic [LEN_W-1:0]  len_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              so_i,
   output logic              si_o,
   output logic              done_o,
   output logic              len_nz_o,
   output logic [DATA_W-1:0] rdata_o
);

   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DATA_W);

   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] bit_q;
   logic [LEN_W-1:0]  cnt_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  len_sat_s;

   // Oversized lengths clamp to the widest transfer the data buses can carry.
   always_comb begin
      len_sat_s = len_i;
      if (len_i > LEN_MAX) begin
         len_sat_s = LEN_MAX;
      end else begin
         len_sat_s = len_i;
      end
   end

   // bit_q is a one-hot pointer to the rdata slot filled by the current cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wdata_q <= '0;
         rdata_q <= '0;
         bit_q   <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
      end else if (load_i) begin
         wdata_q <= wdata_i;
         rdata_q <= '0;
         bit_q   <= DATA_W'(1);
         cnt_q   <= '0;
         len_q   <= len_sat_s;
      end else if (shift_i) begin
         wdata_q <= wdata_q >> 1;
         rdata_q <= rdata_q | (bit_q & {DATA_W{so_i}});
         bit_q   <= bit_q << 1;
         cnt_q   <= cnt_q + LEN_W'(1);
      end else begin
         wdata_q <= wdata_q;
         rdata_q <= rdata_q;
         bit_q   <= bit_q;
         cnt_q   <= cnt_q;
         len_q   <= len_q;
      end
   end

   assign si_o     = wdata_q[0];
   assign done_o   = shift_i && (cnt_q == (len_q - LEN_W'(1)));
   assign len_nz_o = (len_q != '0);
   assign rdata_o  = rdata_q;

endmodule

// File: rtl/mbisr_chain_ctrl.sv
// Command sequencer for one MBISR repair chain: capture, shift, respond,
// with the chain clock enabled only while capturing or shifting.
module mbisr_chain_ctrl
   import mbisr_chain_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic [DATA_W-1:0] cmd_wdata,
   input  logic              cfg_msel,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              busy,
   output logic              chain_clk_en,
   output logic              chain_se,
   output logic              chain_si,
   output logic              chain_msel,
   input  logic              chain_so
);

   state_e state_q;
   op_e    op_q;
   logic   rsp_valid_q;
   logic   clk_en_q;
   logic   se_q;
   logic   msel_q;
   logic   busy_q;
   logic   accept_s;
   logic   done_s;
   logic   len_nz_s;

   assign accept_s = (state_q == ST_IDLE) && cmd_valid;

   mbisr_chain_shifter #(
      .DATA_W (DATA_W),
      .LEN_W  (LEN_W)
   ) u_shifter (
      .clk_i    (CLK),
      .rst_i    (RST),
      .load_i   (accept_s),
      .shift_i  (state_q == ST_SHIFT),
      .len_i    (cmd_len),
      .wdata_i  (cmd_wdata),
      .so_i     (chain_so),
      .si_o     (chain_si),
      .done_o   (done_s),
      .len_nz_o (len_nz_s),
      .rdata_o  (rsp_rdata)
   );

   // Main FSM; every chain-facing output is registered alongside the state.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_NOP;
         rsp_valid_q <= 1'b0;
         clk_en_q    <= 1'b0;
         se_q        <= 1'b0;
         msel_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cmd_valid) begin
                  op_q   <= op_e'(cmd_op);
                  msel_q <= cfg_msel;
                  busy_q <= 1'b1;
                  case (op_e'(cmd_op))
                     OP_CAPTURE, OP_CAPTURE_SHIFT: begin
                        state_q  <= ST_CAPTURE;
                        clk_en_q <= 1'b1;
                        se_q     <= 1'b0;
                     end
                     OP_SHIFT: begin
                        if (cmd_len != '0) begin
                           state_q  <= ST_SHIFT;
                           clk_en_q <= 1'b1;
                           se_q     <= 1'b1;
                        end else begin
                           state_q     <= ST_RESP;
                           rsp_valid_q <= 1'b1;
                        end
                     end
                     default: begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                     end
                  endcase
               end
            end
            ST_CAPTURE: begin
               if ((op_q == OP_CAPTURE_SHIFT) && len_nz_s) begin
                  state_q <= ST_SHIFT;
                  se_q    <= 1'b1;
               end else begin
                  state_q     <= ST_RESP;
                  clk_en_q    <= 1'b0;
                  rsp_valid_q <= 1'b1;
               end
            end
            ST_SHIFT: begin
               if (done_s) begin
                  state_q     <= ST_RESP;
                  clk_en_q    <= 1'b0;
                  se_q        <= 1'b0;
                  rsp_valid_q <= 1'b1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  state_q     <= ST_IDLE;
                  rsp_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               rsp_valid_q <= 1'b0;
               clk_en_q    <= 1'b0;
               se_q        <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_ready    = (state_q == ST_IDLE) && !RST;
   assign rsp_valid    = rsp_valid_q;
   assign busy         = busy_q;
   assign chain_clk_en = clk_en_q;
   assign chain_se     = se_q;
   assign chain_msel   = msel_q;

endmodule

// File: tb/tb_mbisr_chain_ctrl.sv
// Directed bench for mbisr_chain_ctrl against a 26-bit repair-chain model.
module tb_mbisr_chain_ctrl;

   localparam int DATA_W = 32;
   localparam int LEN_W  = 6;
   localparam int CH_LEN = 26;

   logic              CLK = 1'b0;
   logic              RST;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [LEN_W-1:0]  cmd_len;
   logic [DATA_W-1:0] cmd_wdata;
   logic              cfg_msel;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              busy;
   logic              chain_clk_en;
   logic              chain_se;
   logic              chain_si;
   logic              chain_msel;
   logic              chain_so;

   logic [CH_LEN-1:0] chain_m = '0;
   logic [CH_LEN-1:0] chain_d = '0;
   int cap_cnt   = 0;
   int shift_cnt = 0;
   int errors    = 0;
   int checks    = 0;

   mbisr_chain_ctrl #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_len      (cmd_len),
      .cmd_wdata    (cmd_wdata),
      .cfg_msel     (cfg_msel),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .busy         (busy),
      .chain_clk_en (chain_clk_en),
      .chain_se     (chain_se),
      .chain_si     (chain_si),
      .chain_msel   (chain_msel),
      .chain_so     (chain_so)
   );

   always #5 CLK = ~CLK;

   // Chain model: gated clock, SI enters at the far end, bit 0 drives SO.
   assign chain_so = chain_m[0];
   always @(posedge CLK) begin
      if (chain_clk_en) begin
         if (chain_se) begin
            chain_m   <= {chain_si, chain_m[CH_LEN-1:1]};
            shift_cnt <= shift_cnt + 1;
         end else begin
            chain_m <= chain_d;
            cap_cnt <= cap_cnt + 1;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issue one command and return cycles from accept until rsp_valid.
   task automatic run_cmd(input logic [1:0] op, input logic [LEN_W-1:0] len,
                          input logic [DATA_W-1:0] wd, input logic msel, output int lat);
      @(negedge CLK);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_len   = len;
      cmd_wdata = wd;
      cfg_msel  = msel;
      check("cmd_ready_before_accept", {63'd0, cmd_ready}, 64'd1);
      @(posedge CLK);
      #1;
      cmd_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 100) begin
         @(posedge CLK);
         #1;
         lat++;
      end
   endtask

   task automatic finish_rsp();
      rsp_ready = 1'b1;
      @(posedge CLK);
      #1;
      rsp_ready = 1'b0;
   endtask

   initial begin
      int lat;
      int c0;
      int s0;
      RST = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_len = '0; cmd_wdata = '0;
      cfg_msel = 1'b0; rsp_ready = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      check("ready_in_reset", {63'd0, cmd_ready}, 64'd0);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
      check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      check("rst_rdata", {32'd0, rsp_rdata}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_clk_en", {63'd0, chain_clk_en}, 64'd0);
      check("rst_se", {63'd0, chain_se}, 64'd0);
      check("rst_si", {63'd0, chain_si}, 64'd0);
      check("rst_msel", {63'd0, chain_msel}, 64'd0);

      // CAPTURE preloads the chain with all ones.
      chain_d = 26'h3FFFFFF; c0 = cap_cnt; s0 = shift_cnt;
      run_cmd(2'd1, 6'd0, 32'h0, 1'b0, lat);
      check("cap_latency", 64'(lat), 64'd2);
      check("cap_cycles", 64'(cap_cnt - c0), 64'd1);
      check("cap_no_shift", 64'(shift_cnt - s0), 64'd0);
      check("cap_chain", {38'd0, chain_m}, 64'h3FFFFFF);
      finish_rsp();

      // SHIFT 26 bits of alternating data.
      c0 = cap_cnt; s0 = shift_cnt;
      run_cmd(2'd2, 6'd26, 32'h2AAAAAA, 1'b0, lat);
      check("shift26_latency", 64'(lat), 64'd27);
      check("shift26_rdata", {32'd0, rsp_rdata}, 64'h3FFFFFF);
      check("shift26_chain", {38'd0, chain_m}, 64'h2AAAAAA);
      check("shift26_cycles", 64'(shift_cnt - s0), 64'd26);
      check("shift26_no_cap", 64'(cap_cnt - c0), 64'd0);
      check("shift26_clk_off", {63'd0, chain_clk_en}, 64'd0);
      finish_rsp();

      // CAPTURE_SHIFT reads parallel data back and zero-fills the chain.
      chain_d = 26'h1234567; c0 = cap_cnt; s0 = shift_cnt;
      run_cmd(2'd3, 6'd26, 32'h0, 1'b0, lat);
      check("cs_latency", 64'(lat), 64'd28);
      check("cs_cap_cycles", 64'(cap_cnt - c0), 64'd1);
      check("cs_shift_cycles", 64'(shift_cnt - s0), 64'd26);
      check("cs_rdata", {32'd0, rsp_rdata}, 64'h1234567);
      check("cs_chain", {38'd0, chain_m}, 64'h0);
      finish_rsp();

      // Zero-length SHIFT and NOP never clock the chain.
      c0 = cap_cnt; s0 = shift_cnt;
      run_cmd(2'd2, 6'd0, 32'hFFFFFFFF, 1'b0, lat);
      check("len0_latency", 64'(lat), 64'd1);
      check("len0_rdata", {32'd0, rsp_rdata}, 64'h0);
      finish_rsp();
      run_cmd(2'd0, 6'd9, 32'h12345678, 1'b0, lat);
      check("nop_latency", 64'(lat), 64'd1);
      check("nop_rdata", {32'd0, rsp_rdata}, 64'h0);
      check("nop_len0_no_clk", 64'((cap_cnt - c0) + (shift_cnt - s0)), 64'd0);
      finish_rsp();

      // Oversized length saturates to 32; tail of rdata is the head of wdata.
      s0 = shift_cnt;
      run_cmd(2'd2, 6'd40, 32'hDEADBEEF, 1'b0, lat);
      check("sat_latency", 64'(lat), 64'd33);
      check("sat_cycles", 64'(shift_cnt - s0), 64'd32);
      check("sat_rdata", {32'd0, rsp_rdata}, 64'hBC000000);
      check("sat_chain", {38'd0, chain_m}, 64'h37AB6FB);
      finish_rsp();

      // Backpressure with an ignored command and a toggled cfg_msel.
      s0 = shift_cnt;
      run_cmd(2'd2, 6'd4, 32'h5, 1'b1, lat);
      check("bp_latency", 64'(lat), 64'd5);
      cfg_msel = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cmd_valid = (i == 5);
         cmd_op    = 2'd0;
         @(posedge CLK);
         #1;
         cmd_valid = 1'b0;
         check("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
         check("bp_rdata", {32'd0, rsp_rdata}, 64'hB);
         check("bp_cmd_ready", {63'd0, cmd_ready}, 64'd0);
      end
      check("bp_shift_cycles", 64'(shift_cnt - s0), 64'd4);
      check("bp_msel_held", {63'd0, chain_msel}, 64'd1);
      check("bp_busy", {63'd0, busy}, 64'd1);
      finish_rsp();
      check("bp_after_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      check("bp_after_cmd_ready", {63'd0, cmd_ready}, 64'd1);
      check("bp_after_msel", {63'd0, chain_msel}, 64'd1);
      run_cmd(2'd0, 6'd0, 32'h0, 1'b0, lat);
      check("msel_new_accept", {63'd0, chain_msel}, 64'd0);
      finish_rsp();

      // Reset during shift cycle k=5 of a 20-bit SHIFT.
      @(negedge CLK);
      cmd_valid = 1'b1; cmd_op = 2'd2; cmd_len = 6'd20; cmd_wdata = 32'hFFFFF;
      @(posedge CLK);
      #1;
      cmd_valid = 1'b0;
      repeat (5) @(posedge CLK);
      #1;
      check("pre_rst_clk_en", {63'd0, chain_clk_en}, 64'd1);
      check("pre_rst_se", {63'd0, chain_se}, 64'd1);
      #1;
      RST = 1'b1;
      #1;
      check("mid_rst_clk_en", {63'd0, chain_clk_en}, 64'd0);
      check("mid_rst_se", {63'd0, chain_se}, 64'd0);
      check("mid_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      check("mid_rst_busy", {63'd0, busy}, 64'd0);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      check("post_rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
      for (int i = 0; i < 25; i++) begin
         @(posedge CLK);
         #1;
         if (i % 8 == 0) begin
            check("post_rst_no_rsp", {63'd0, rsp_valid}, 64'd0);
         end
      end
      check("post_rst_clk_off", {63'd0, chain_clk_en}, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mbisr_chain_ctrl.md
Name: mbisr_chain_ctrl

Overview:
Sequencer for one MBISR repair-register chain built from per-memory shift/capture wrapper registers. It accepts host commands to capture parallel fuse/repair data into the chain and to shift up to DATA_W bits through it. It returns the bits shifted out. It sits between the BISR/fuse-controller host and the chain's SE/SI/SO/MSEL pins, and it gates the chain clock so the chain only updates when commanded.

Parameters:
DATA_W, 32, max bits per SHIFT command and width of wdata/rdata
LEN_W, 6, width of cmd_len (must satisfy 2**LEN_W > DATA_W)

Ports:
CLK  in  1  single clock; chain registers share it through an external ICG enabled by chain_clk_en
RST  in  1  asynchronous reset, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  controller accepts command (IDLE only)
cmd_op  in  2  0=NOP, 1=CAPTURE, 2=SHIFT, 3=CAPTURE_SHIFT
cmd_len  in  LEN_W  shift bit count, 0..DATA_W
cmd_wdata  in  DATA_W  serial-in data, bit 0 shifted first
cfg_msel  in  1  chain bypass select, sampled only in IDLE
rsp_valid  out  1  command complete
rsp_ready  in  1  host accepts response
rsp_rdata  out  DATA_W  bits shifted out, first bit in bit 0, unused MSBs 0
busy  out  1  state != IDLE
chain_clk_en  out  1  chain clock enable
chain_se  out  1  chain shift enable (0 = parallel capture)
chain_si  out  1  chain serial input
chain_msel  out  1  chain MSEL
chain_so  in  1  chain serial output (negedge-retimed, stable at posedge)

Behaviour:
- Reset (async, RST=1): state=IDLE; cmd_ready=1 once RST deasserts; rsp_valid=0, rsp_rdata=0, busy=0, chain_clk_en=0, chain_se=0, chain_si=0, chain_msel=0. Reset mid-command aborts it. chain_clk_en drops asynchronously, no response is issued, and chain contents are left undefined for the host.
- States: IDLE, CAPTURE, SHIFT, RESP. All outputs are registered except cmd_ready = (state==IDLE) && !RST.
- IDLE: on the cmd_valid&&cmd_ready posedge, latch op, len, wdata, and chain_msel<=cfg_msel.
  - op=NOP, or op=SHIFT with len=0 -> RESP.
  - op=CAPTURE or CAPTURE_SHIFT -> CAPTURE.
  - op=SHIFT with len>0 -> SHIFT.
- CAPTURE: exactly one cycle with chain_clk_en=1, chain_se=0.
  - Next state is SHIFT if op=CAPTURE_SHIFT and len>0, else RESP.
- SHIFT: chain_clk_en=1, chain_se=1 for exactly len cycles. Bit counter k runs 0..len-1.
  - chain_si=wdata[k] during cycle k.
  - At the posedge ending cycle k, rdata[k]<=chain_so. The chain's retime flop presents the pre-shift bit 0 at that posedge.
  - After the cycle with k=len-1 -> RESP, with chain_clk_en=0 and chain_se=0 in the same edge.
- cmd_len>DATA_W is saturated to DATA_W.
- RESP: rsp_valid=1 and rsp_rdata held stable until rsp_ready. On the handshake posedge -> IDLE, rsp_valid=0, and cmd_ready=1 from the next cycle.
  - Minimum latency from command accept to rsp_valid: NOP 1 cycle, CAPTURE 2 cycles, SHIFT len+1 cycles, CAPTURE_SHIFT len+2 cycles.
- The chain never sees a clock edge outside CAPTURE/SHIFT states (chain_clk_en=0). chain_msel changes only on command accept.
- cmd_valid outside IDLE is ignored (no queueing). The host must hold cmd_valid and fields stable until accepted.

Decomposition:
- Package mbisr_chain_pkg holds:
  - the op enum (OP_NOP/OP_CAPTURE/OP_SHIFT/OP_CAPTURE_SHIFT);
  - the state enum;
  - the DATA_W/LEN_W defaults.
- One natural sub-module: mbisr_chain_shifter, holding the bit counter, the wdata serializer and the rdata deserializer. It takes a start/len input and produces a done output. The FSM stays in the top module.

Test Plan:
- Reset: RST=1 mid-SHIFT at k=5 -> chain_clk_en/chain_se/rsp_valid=0 immediately. After release, cmd_ready=1 and no rsp is issued.
- SHIFT len=26, wdata=0x2AAAAAA, against a 26-bit chain model preloaded with 0x3FFFFFF -> rsp_rdata=0x3FFFFFF. The chain then holds 0x2AAAAAA, and rsp_valid occurs 27 cycles after accept.
- CAPTURE_SHIFT len=26, chain D=0x1234567, wdata=0 -> exactly one capture cycle with chain_se=0. rsp_rdata=0x1234567, and the chain is all-zero afterward.
- SHIFT len=0 and NOP -> rsp_valid 1 cycle after accept, rsp_rdata=0, and chain_clk_en never asserts.
- SHIFT len=40 (>DATA_W=32) -> exactly 32 shift cycles, with rdata bits beyond the chain's 26-bit length equal to the leading wdata bits.
- Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid/rsp_rdata stable, cmd_ready=0, and a cmd_valid pulse is ignored. cfg_msel toggled during the command leaves chain_msel unchanged until the next accept.
